sha1_padder: RTL and testbench

- Sequential front end for the SHA-1 block-chain core.
- Accepts an arbitrary-length byte message as a valid/ready stream.
- Emits FIPS 180-4 padded 512-bit blocks: message bytes, 0x80, zero fill, then the 64-bit big-endian bit length.
- Output is one block per handshake, in the same big-endian layout the core consumes: byte 0 at bits [511:504].

---
 rtl/sha1_pkg.sv | 38 +++
 rtl/sha1_padder_if.sv | 23 ++
 rtl/sha1_padder.sv | 123 ++++++++++++
 tb/tb_sha1_padder.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/sha1_pkg.sv
// Shared SHA-1 constants, types and helpers for the padder and the block-chain core.
package sha1_pkg;

    localparam int unsigned BLOCK_W     = 512;
    localparam int unsigned DIGEST_W    = 160;
    localparam int unsigned BLOCK_BYTES = BLOCK_W / 8;
    localparam int unsigned LEN_W       = 64;
    localparam int unsigned LEN_POS     = 56;

    localparam logic [7:0] PAD_BYTE = 8'h80;

    localparam logic [31:0] IV0 = 32'h67452301;
    localparam logic [31:0] IV1 = 32'hEFCDAB89;
    localparam logic [31:0] IV2 = 32'h98BADCFE;
    localparam logic [31:0] IV3 = 32'h10325476;
    localparam logic [31:0] IV4 = 32'hC3D2E1F0;

    // Byte 0 is the leftmost (most significant) byte, matching the core's big-endian view.
    typedef logic [0:BLOCK_BYTES-1][7:0] block_t;

    typedef enum logic [1:0] {
        ST_FILL,
        ST_FULL,
        ST_TAIL,
        ST_LEN
    } pad_state_e;

    // Places a 64-bit big-endian bit length into the last eight bytes of a block.
    function automatic block_t put_len(input block_t blk, input logic [LEN_W-1:0] len);
        block_t r;
        r = blk;
        for (int b = 0; b < 8; b++) begin
            r[LEN_POS + b] = len[LEN_W - 1 - 8*b -: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/sha1_padder_if.sv
// Byte-stream input and padded-block output of the SHA-1 padder.
interface sha1_padder_if;
    import sha1_pkg::*;

    logic [7:0]         in_data;
    logic               in_valid;
    logic               in_last;
    logic               in_ready;
    logic [BLOCK_W-1:0] blk_data;
    logic               blk_valid;
    logic               blk_last;
    logic               blk_ready;

    modport slave (
        input  in_data, in_valid, in_last, blk_ready,
        output in_ready, blk_data, blk_valid, blk_last
    );

    modport master (
        output in_data, in_valid, in_last, blk_ready,
        input  in_ready, blk_data, blk_valid, blk_last
    );
endinterface

// File: rtl/sha1_padder.sv
// Collects message bytes into 512-bit blocks and appends SHA-1 padding and bit length.
module sha1_padder
    import sha1_pkg::*;
#(
    parameter int unsigned CNT_W = 61
) (
    input  logic          clk,
    input  logic          rst,
    sha1_padder_if.slave  bus
);

    localparam int unsigned IDX_W = 6;

    pad_state_e       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    block_t           buf_q, buf_d;
    logic             pend_q, pend_d;
    logic             fit_q, fit_d;

    logic [CNT_W-1:0] cnt_inc;
    logic [LEN_W-1:0] len_cur;
    logic [LEN_W-1:0] len_inc;

    assign cnt_inc = cnt_q + CNT_W'(1);
    assign len_cur = LEN_W'({cnt_q, 3'b000});
    assign len_inc = LEN_W'({cnt_inc, 3'b000});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_FILL;
            idx_q   <= '0;
            cnt_q   <= '0;
            buf_q   <= '0;
            pend_q  <= 1'b0;
            fit_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            pend_q  <= pend_d;
            fit_q   <= fit_d;
        end
    end

    // Buffer fill, pad insertion and length insertion in one update.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        pend_d  = pend_q;
        fit_d   = fit_q;

        unique case (state_q)
            ST_FILL: begin
                if (bus.in_valid) begin
                    buf_d[idx_q] = bus.in_data;
                    idx_d        = idx_q + IDX_W'(1);
                    cnt_d        = cnt_inc;
                    if (idx_q == IDX_W'(BLOCK_BYTES - 1)) begin
                        state_d = ST_FULL;
                        pend_d  = bus.in_last;
                    end else if (bus.in_last) begin
                        state_d                   = ST_TAIL;
                        buf_d[idx_q + IDX_W'(1)]  = PAD_BYTE;
                        // Length fits only if the pad byte lands at or below byte 55.
                        if (idx_q < IDX_W'(LEN_POS - 1)) begin
                            buf_d = put_len(buf_d, len_inc);
                            fit_d = 1'b1;
                        end else begin
                            fit_d = 1'b0;
                        end
                    end
                end
            end
            ST_FULL: begin
                if (bus.blk_ready) begin
                    buf_d = '0;
                    idx_d = '0;
                    if (pend_q) begin
                        state_d  = ST_TAIL;
                        buf_d[0] = PAD_BYTE;
                        buf_d    = put_len(buf_d, len_cur);
                        fit_d    = 1'b1;
                        pend_d   = 1'b0;
                    end else begin
                        state_d = ST_FILL;
                    end
                end
            end
            ST_TAIL: begin
                if (bus.blk_ready) begin
                    if (fit_q) begin
                        state_d = ST_FILL;
                        cnt_d   = '0;
                        idx_d   = '0;
                        buf_d   = '0;
                    end else begin
                        state_d = ST_LEN;
                        buf_d   = put_len('0, len_cur);
                    end
                end
            end
            ST_LEN: begin
                if (bus.blk_ready) begin
                    state_d = ST_FILL;
                    cnt_d   = '0;
                    idx_d   = '0;
                    buf_d   = '0;
                end
            end
            default: state_d = ST_FILL;
        endcase
    end

    assign bus.in_ready  = (state_q == ST_FILL);
    assign bus.blk_valid = (state_q != ST_FILL);
    assign bus.blk_data  = buf_q;
    assign bus.blk_last  = ((state_q == ST_TAIL) && fit_q) || (state_q == ST_LEN);

endmodule

// File: tb/tb_sha1_padder.sv
// Directed self-checking bench for sha1_padder using hand-computed padded blocks.
module tb_sha1_padder;
    import sha1_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sha1_padder_if bus ();

    sha1_padder #(.CNT_W(61)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_err = 0;
    int n_hs  = 0;

    always @(posedge clk) if (bus.blk_valid === 1'b1 && bus.blk_ready === 1'b1) n_hs++;

    logic [511:0] exp_abc;
    logic [511:0] exp_abcd;

    task automatic send_byte(input logic [7:0] d, input logic last);
        int guard;
        guard        = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
        while (bus.in_ready !== 1'b1 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) begin
            n_vec++; n_err++;
            $display("FAIL send_timeout: in_ready=%b required 1", bus.in_ready);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic get_block(output logic [511:0] d, output logic l);
        int guard;
        guard = 0;
        while (bus.blk_valid !== 1'b1 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) begin
            n_vec++; n_err++;
            $display("FAIL blk_timeout: blk_valid=%b required 1", bus.blk_valid);
        end
        d = bus.blk_data;
        l = bus.blk_last;
        @(negedge clk);
    endtask

    task automatic test_reset();
        n_vec++; if (bus.blk_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b required 0", bus.blk_valid); end
        n_vec++; if (bus.blk_last !== 1'b0) begin n_err++; $display("FAIL rst_last: got %b required 0", bus.blk_last); end
        n_vec++; if (bus.blk_data !== 512'h0) begin n_err++; $display("FAIL rst_data: got %h required 0", bus.blk_data); end
        rst = 1'b0;
        @(negedge clk);
        n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready: got %b required 1", bus.in_ready); end
    endtask

    task automatic test_abc(input string tag);
        logic [511:0] d;
        logic         l;
        send_byte(8'h61, 1'b0);
        send_byte(8'h62, 1'b0);
        send_byte(8'h63, 1'b1);
        n_vec++; if (bus.blk_valid !== 1'b1) begin n_err++; $display("FAIL %s_latency: blk_valid=%b required 1", tag, bus.blk_valid); end
        get_block(d, l);
        n_vec++; if (d !== exp_abc) begin n_err++; $display("FAIL %s_data: got %h required %h", tag, d, exp_abc); end
        n_vec++; if (l !== 1'b1) begin n_err++; $display("FAIL %s_last: got %b required 1", tag, l); end
        n_vec++; if (bus.blk_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_err++; $display("FAIL %s_done: valid=%b ready=%b required 0/1", tag, bus.blk_valid, bus.in_ready);
        end
    endtask

    task automatic test_55_zeros();
        logic [511:0] d, e;
        logic         l;
        e         = '0;
        e[71:64]  = 8'h80;
        e[63:0]   = 64'h1B8;
        for (int i = 0; i < 55; i++) send_byte(8'h00, i == 54);
        get_block(d, l);
        n_vec++; if (d !== e) begin n_err++; $display("FAIL z55_data: got %h required %h", d, e); end
        n_vec++; if (l !== 1'b1) begin n_err++; $display("FAIL z55_last: got %b required 1", l); end
    endtask

    task automatic test_56_zeros();
        logic [511:0] d, e1, e2;
        logic         l;
        e1        = '0;
        e1[63:56] = 8'h80;
        e2        = '0;
        e2[63:0]  = 64'h1C0;
        for (int i = 0; i < 56; i++) send_byte(8'h00, i == 55);
        get_block(d, l);
        n_vec++; if (d !== e1) begin n_err++; $display("FAIL z56_b1_data: got %h required %h", d, e1); end
        n_vec++; if (l !== 1'b0) begin n_err++; $display("FAIL z56_b1_last: got %b required 0", l); end
        n_vec++; if (bus.blk_valid !== 1'b1) begin n_err++; $display("FAIL z56_consec: blk_valid=%b required 1", bus.blk_valid); end
        get_block(d, l);
        n_vec++; if (d !== e2) begin n_err++; $display("FAIL z56_b2_data: got %h required %h", d, e2); end
        n_vec++; if (l !== 1'b1) begin n_err++; $display("FAIL z56_b2_last: got %b required 1", l); end
    endtask

    task automatic test_64_seq();
        logic [511:0] d, e1, e2;
        logic         l;
        e1 = 512'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f202122232425262728292a2b2c2d2e2f303132333435363738393a3b3c3d3e3f;
        e2          = '0;
        e2[511:504] = 8'h80;
        e2[63:0]    = 64'h200;
        for (int i = 0; i < 64; i++) send_byte(8'(i), i == 63);
        n_vec++; if (bus.blk_valid !== 1'b1) begin n_err++; $display("FAIL s64_latency: blk_valid=%b required 1", bus.blk_valid); end
        get_block(d, l);
        n_vec++; if (d !== e1) begin n_err++; $display("FAIL s64_b1_data: got %h required %h", d, e1); end
        n_vec++; if (l !== 1'b0) begin n_err++; $display("FAIL s64_b1_last: got %b required 0", l); end
        n_vec++; if (bus.blk_valid !== 1'b1) begin n_err++; $display("FAIL s64_consec: blk_valid=%b required 1", bus.blk_valid); end
        get_block(d, l);
        n_vec++; if (d !== e2) begin n_err++; $display("FAIL s64_b2_data: got %h required %h", d, e2); end
        n_vec++; if (l !== 1'b1) begin n_err++; $display("FAIL s64_b2_last: got %b required 1", l); end
    endtask

    task automatic test_stall();
        int h0;
        bus.blk_ready = 1'b0;
        h0 = n_hs;
        send_byte(8'h61, 1'b0);
        send_byte(8'h62, 1'b0);
        send_byte(8'h63, 1'b1);
        for (int c = 0; c < 5; c++) begin
            n_vec++; if (bus.blk_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
                n_err++; $display("FAIL stall_hs_c%0d: valid=%b ready=%b required 1/0", c, bus.blk_valid, bus.in_ready);
            end
            n_vec++; if (bus.blk_data !== exp_abc || bus.blk_last !== 1'b1) begin
                n_err++; $display("FAIL stall_hold_c%0d: got %h last %b required %h last 1", c, bus.blk_data, bus.blk_last, exp_abc);
            end
            @(negedge clk);
        end
        bus.blk_ready = 1'b1;
        @(negedge clk);
        n_vec++; if (n_hs - h0 !== 1) begin n_err++; $display("FAIL stall_hs_count: got %0d required 1", n_hs - h0); end
        n_vec++; if (bus.blk_valid !== 1'b0) begin n_err++; $display("FAIL stall_release: blk_valid=%b required 0", bus.blk_valid); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 30; i++) send_byte(8'h5a, 1'b0);
        rst = 1'b1;
        #1;
        n_vec++; if (bus.blk_valid !== 1'b0 || bus.blk_data !== 512'h0) begin
            n_err++; $display("FAIL mid_rst_out: valid=%b data=%h required 0/0", bus.blk_valid, bus.blk_data);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        test_abc("after_rst");
    endtask

    task automatic test_back_to_back();
        logic [511:0] d;
        logic         l;
        test_abc("b2b_first");
        send_byte(8'h61, 1'b0);
        send_byte(8'h62, 1'b0);
        send_byte(8'h63, 1'b0);
        send_byte(8'h64, 1'b1);
        get_block(d, l);
        n_vec++; if (d !== exp_abcd) begin n_err++; $display("FAIL b2b_abcd_data: got %h required %h", d, exp_abcd); end
        n_vec++; if (l !== 1'b1) begin n_err++; $display("FAIL b2b_abcd_last: got %b required 1", l); end
    endtask

    initial begin
        exp_abc            = '0;
        exp_abc[511:480]   = 32'h61626380;
        exp_abc[63:0]      = 64'h18;
        exp_abcd           = '0;
        exp_abcd[511:472]  = 40'h6162636480;
        exp_abcd[63:0]     = 64'h20;

        rst           = 1'b1;
        bus.in_data   = 8'h00;
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.blk_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);

        test_reset();
        test_abc("abc");
        test_55_zeros();
        test_56_zeros();
        test_64_seq();
        test_stall();
        test_reset_mid();
        test_back_to_back();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
